tdm_demux_1to4: RTL and testbench
=================================

// Module: tdm_demux_1to4
// PURPOSE
//  Time-division demultiplexer: the receive end of the team's serial mux chain.
//  - Accepts one time-multiplexed stream of WIDTH-bit beats.
//  - Slot 0 of each frame is marked by frame_sync; the block steers each beat to its lane register.
//  - Restores the per-lane signals that the 4:1 mux tree serialised upstream; sits between the serial link and the lane consumers.
// PARAMETERS
//  WIDTH  1  bits per beat / per lane
//  LANES  4  lanes per frame (slots 0..LANES-1); legal values 2..16
//  SELW   2  slot counter width; must equal clog2(LANES)
// PORTS
//  clk         in   1            rising-edge clock
//  rst_n       in   1            asynchronous active-low reset
//  din         in   WIDTH        serial beat
//  din_valid   in   1            din carries a beat this cycle
//  frame_sync  in   1            qualifies din as slot 0 (only meaningful with din_valid)
//  resync      in   1            synchronous request to drop lock and re-hunt
//  lane_data   out  LANES*WIDTH  lane k occupies bits [k*WIDTH +: WIDTH]
//  lane_valid  out  LANES        one-cycle pulse: lane k updated this cycle
//  frame_done  out  1            one-cycle pulse: slot LANES-1 of a clean frame captured
//  locked      out  1            1 in LOCKED state
//  sync_err    out  1            one-cycle pulse: frame_sync arrived while slot != 0
//  err_cnt     out  8            saturating count of sync_err events
//  slot        out  SELW         slot index expected for the next beat
// BEHAVIOUR
//  Reset
//   - Clock and reset: single clock; reset is asynchronous and active-low (rst_n).
//   - On reset all outputs are 0, state=HUNT, slot=0.
//  Beats and timing
//   - A beat is a cycle with din_valid=1.
//   - With din_valid=0, nothing changes: slot holds and every pulse output is 0.
//   - frame_sync with din_valid=0 is ignored.
//   - Latency: a beat captured at edge N shows on lane_data, lane_valid, frame_done and sync_err after edge N (one register stage).
//   - lane_data holds its last value until that lane is overwritten.
//  State HUNT
//   - A beat with frame_sync=0 is discarded; no pulses.
//   - A beat with frame_sync=1 writes lane 0, pulses lane_valid[0], sets slot=1 and moves to LOCKED.
//  State LOCKED, beat with frame_sync=0
//   - Writes lane[slot] and pulses lane_valid[slot].
//   - slot increments modulo LANES (LANES-1 wraps to 0).
//   - If slot was LANES-1 and no sync_err occurred since the last slot-0 capture, frame_done pulses.
//  State LOCKED, beat with frame_sync=1 and slot=0
//   - Normal frame start: writes lane 0, slot=1.
//  State LOCKED, beat with frame_sync=1 and slot!=0
//   - Realign: sync_err pulses and err_cnt increments (saturates at 255).
//   - The beat writes lane 0 and slot=1; the partial frame gets no frame_done.
//   - The state stays LOCKED.
//  resync
//   - resync=1 forces HUNT and slot=0 at the next edge and discards any beat in that cycle.
//   - lane_data and err_cnt are retained.
//  Reset mid-frame
//   - Asynchronous clear to the reset values; the next frame must be re-hunted.
//  Boundaries
//   - err_cnt holds at 255.
//   - With LANES not a power of two, slot never exceeds LANES-1.
// TESTING
//  1. Reset, then 5 beats with no frame_sync (din=1) -> locked=0, lane_valid=0, lane_data=0.
//  2. Beats a,b,c,d = 0,1,0,1 with frame_sync on a -> lane_data=4'b1010 (lane0=0, lane3=1).
//     Also: lane_valid pulses 0001, 0010, 0100, 1000 on successive cycles; frame_done on the 4th; slot returns to 0.
//  3. Sync, 2 beats, then frame_sync again (slot=2) -> sync_err=1, err_cnt=1, lane0 rewritten, slot=1.
//     Also: no frame_done for the aborted frame, and the next complete frame gives frame_done.
//  4. Sync frame with din_valid gaps (1,0,0,1,1,0,1) -> same lane_data as back-to-back.
//     Also: slot holds during the gaps and lane_valid pulses only on valid cycles.
//  5. resync mid-frame at slot=2 -> locked=0, slot=0, lane_data unchanged, following non-sync beats ignored.
//     Also: 256 forced sync errors give err_cnt=255.
//  6. Assert rst_n=0 between clock edges at slot=3 -> outputs 0 immediately; after release state=HUNT.

Source files
------------

// File: rtl/tdm_demux_1to4.sv
`default_nettype none
// ============================================================================
// tdm_demux_1to4 : receive-side TDM demultiplexer, frame_sync aligned lanes
// Revision       : 1.0
// ============================================================================
module tdm_demux_1to4 #(
  parameter int WIDTH = 1,
  parameter int LANES = 4,
  parameter int SELW  = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [WIDTH-1:0]       din_i,
  input  logic                   din_valid_i,
  input  logic                   frame_sync_i,
  input  logic                   resync_i,
  output logic [LANES*WIDTH-1:0] lane_data_o,
  output logic [LANES-1:0]       lane_valid_o,
  output logic                   frame_done_o,
  output logic                   locked_o,
  output logic                   sync_err_o,
  output logic [7:0]             err_cnt_o,
  output logic [SELW-1:0]        slot_o
);

  typedef enum logic [0:0] {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } state_e;

  localparam logic [SELW-1:0] c_LAST_SLOT = SELW'(LANES - 1);

  state_e                 state_q;
  logic [SELW-1:0]        slot_q;
  logic [LANES*WIDTH-1:0] lane_data_q;
  logic [LANES-1:0]       lane_valid_q;
  logic                   frame_done_q;
  logic                   sync_err_q;
  logic [7:0]             err_cnt_q;
  logic                   clean_q;

  logic                   w_sync_beat;
  logic                   w_realign;
  logic                   w_data_beat;
  logic [SELW-1:0]        w_slot_next;

  assign w_sync_beat = din_valid_i & frame_sync_i;
  assign w_realign   = (state_q == LOCKED) && (slot_q != '0);
  assign w_data_beat = din_valid_i & ~frame_sync_i & (state_q == LOCKED);
  // Explicit wrap keeps slot inside 0..LANES-1 for non power-of-two LANES
  assign w_slot_next = (slot_q == c_LAST_SLOT) ? '0 : slot_q + SELW'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= HUNT;
      slot_q       <= '0;
      lane_data_q  <= '0;
      lane_valid_q <= '0;
      frame_done_q <= 1'b0;
      sync_err_q   <= 1'b0;
      err_cnt_q    <= '0;
      clean_q      <= 1'b0;
    end else begin
      lane_valid_q <= '0;
      frame_done_q <= 1'b0;
      sync_err_q   <= 1'b0;
      if (resync_i) begin
        state_q <= HUNT;
        slot_q  <= '0;
      end else if (w_sync_beat) begin
        lane_data_q[WIDTH-1:0] <= din_i;
        lane_valid_q[0]        <= 1'b1;
        slot_q                 <= SELW'(1);
        state_q                <= LOCKED;
        // A realigned frame is tainted and will not report frame_done
        if (w_realign) begin
          sync_err_q <= 1'b1;
          clean_q    <= 1'b0;
          if (err_cnt_q != 8'hFF) begin
            err_cnt_q <= err_cnt_q + 8'd1;
          end
        end else begin
          clean_q <= 1'b1;
        end
      end else if (w_data_beat) begin
        for (int k = 0; k < LANES; k++) begin
          if (slot_q == SELW'(k)) begin
            lane_data_q[k*WIDTH +: WIDTH] <= din_i;
            lane_valid_q[k]               <= 1'b1;
          end
        end
        slot_q <= w_slot_next;
        if (slot_q == c_LAST_SLOT) begin
          frame_done_q <= clean_q;
        end
      end
    end
  end

  assign lane_data_o  = lane_data_q;
  assign lane_valid_o = lane_valid_q;
  assign frame_done_o = frame_done_q;
  assign locked_o     = (state_q == LOCKED);
  assign sync_err_o   = sync_err_q;
  assign err_cnt_o    = err_cnt_q;
  assign slot_o       = slot_q;

endmodule
`default_nettype wire

// File: tb/tb_tdm_demux_1to4.sv
`default_nettype none
// ============================================================================
// tb_tdm_demux_1to4 : scoreboard bench for tdm_demux_1to4 (LANES=4 and LANES=3)
// Revision          : 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_tdm_demux_1to4;

  logic       clk;
  logic       rst_n;
  logic       din_i, din_valid_i, frame_sync_i, resync_i;
  logic [3:0] lane_data_o, lane_valid_o;
  logic       frame_done_o, locked_o, sync_err_o;
  logic [7:0] err_cnt_o;
  logic [1:0] slot_o;

  logic [1:0] d3_din;
  logic       d3_valid, d3_fs, d3_rs;
  logic [5:0] d3_ld;
  logic [2:0] d3_lv;
  logic       d3_fd, d3_lk, d3_se;
  logic [7:0] d3_ec;
  logic [1:0] d3_slot;

  tdm_demux_1to4 #(.WIDTH(1), .LANES(4), .SELW(2)) u_dut (
    .clk(clk), .rst_n(rst_n), .din_i(din_i), .din_valid_i(din_valid_i),
    .frame_sync_i(frame_sync_i), .resync_i(resync_i),
    .lane_data_o(lane_data_o), .lane_valid_o(lane_valid_o),
    .frame_done_o(frame_done_o), .locked_o(locked_o), .sync_err_o(sync_err_o),
    .err_cnt_o(err_cnt_o), .slot_o(slot_o)
  );

  tdm_demux_1to4 #(.WIDTH(2), .LANES(3), .SELW(2)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .din_i(d3_din), .din_valid_i(d3_valid),
    .frame_sync_i(d3_fs), .resync_i(d3_rs),
    .lane_data_o(d3_ld), .lane_valid_o(d3_lv),
    .frame_done_o(d3_fd), .locked_o(d3_lk), .sync_err_o(d3_se),
    .err_cnt_o(d3_ec), .slot_o(d3_slot)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] ld;
    logic [3:0] lv;
    logic       fd;
    logic       se;
    logic       lk;
    logic [1:0] sl;
    logic [7:0] ec;
  } obs_t;

  obs_t sb[$];
  int   n_pass  = 0;
  int   n_total = 0;

  // Reference model of the LANES=4 instance
  logic       m_locked;
  int         m_slot;
  logic [3:0] m_ld;
  logic       m_clean;
  int         m_err;

  function automatic obs_t sample();
    obs_t o;
    o.ld = lane_data_o; o.lv = lane_valid_o; o.fd = frame_done_o;
    o.se = sync_err_o;  o.lk = locked_o;     o.sl = slot_o;  o.ec = err_cnt_o;
    return o;
  endfunction

  function automatic void model_reset();
    m_locked = 1'b0; m_slot = 0; m_ld = '0; m_clean = 1'b0; m_err = 0;
    sb.delete();
  endfunction

  // Predicts the outcome of one cycle, pushes it, then applies the cycle
  task automatic beat(input logic d, input logic v, input logic fs, input logic rs);
    obs_t e;
    e = '0;
    if (rs) begin
      m_locked = 1'b0; m_slot = 0;
    end else if (v && fs) begin
      if (m_locked && m_slot != 0) begin
        e.se = 1'b1; m_clean = 1'b0;
        if (m_err < 255) m_err++;
      end else begin
        m_clean = 1'b1;
      end
      m_ld[0] = d; e.lv[0] = 1'b1; m_slot = 1; m_locked = 1'b1;
    end else if (v && m_locked) begin
      m_ld[m_slot] = d; e.lv[m_slot] = 1'b1;
      if (m_slot == 3) begin
        e.fd = m_clean; m_slot = 0;
      end else begin
        m_slot++;
      end
    end
    e.ld = m_ld; e.lk = m_locked; e.sl = 2'(m_slot); e.ec = 8'(m_err);
    sb.push_back(e);
    din_i = d; din_valid_i = v; frame_sync_i = fs; resync_i = rs;
    @(posedge clk);
    #1;
    din_i = 1'b0; din_valid_i = 1'b0; frame_sync_i = 1'b0; resync_i = 1'b0;
  endtask

  task automatic test_reset();
    obs_t got, exp;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_total++;
    if (sample() !== obs_t'(0)) $display("FAIL reset_state got=%h exp=%h", sample(), obs_t'(0));
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    for (int i = 0; i < 5; i++) begin
      beat(1'b1, 1'b1, 1'b0, 1'b0);
      got = sample();
      exp = sb.pop_front();
      n_total++;
      if (got !== exp) $display("FAIL hunt_discard[%0d] got=%h exp=%h", i, got, exp);
      else n_pass++;
    end
    n_total++;
    if (locked_o !== 1'b0 || lane_data_o !== 4'b0000)
      $display("FAIL hunt_idle got lk=%b ld=%b exp lk=0 ld=0000", locked_o, lane_data_o);
    else n_pass++;
  endtask

  task automatic test_frame();
    logic [3:0] dat = 4'b1010;
    obs_t got, exp;
    for (int i = 0; i < 4; i++) begin
      beat(dat[i], 1'b1, (i == 0), 1'b0);
      got = sample();
      exp = sb.pop_front();
      n_total++;
      if (got !== exp) $display("FAIL frame_beat[%0d] got=%h exp=%h", i, got, exp);
      else n_pass++;
    end
    n_total++;
    if (lane_data_o !== 4'b1010 || frame_done_o !== 1'b1 || slot_o !== 2'd0 || lane_valid_o !== 4'b1000)
      $display("FAIL frame_end got ld=%b fd=%b sl=%0d lv=%b exp ld=1010 fd=1 sl=0 lv=1000",
               lane_data_o, frame_done_o, slot_o, lane_valid_o);
    else n_pass++;
  endtask

  task automatic test_realign();
    logic [10:0] dat = 11'b1001_111_0011;
    logic [10:0] fs  = 11'b0001_000_1001;
    obs_t got, exp;
    for (int i = 0; i < 11; i++) begin
      beat(dat[i], 1'b1, fs[i], 1'b0);
      got = sample();
      exp = sb.pop_front();
      n_total++;
      if (got !== exp) $display("FAIL realign_beat[%0d] got=%h exp=%h", i, got, exp);
      else n_pass++;
      if (i == 3) begin
        n_total++;
        if (sync_err_o !== 1'b1 || err_cnt_o !== 8'd1 || slot_o !== 2'd1 ||
            lane_data_o[0] !== 1'b0 || frame_done_o !== 1'b0)
          $display("FAIL realign_err got se=%b ec=%0d sl=%0d l0=%b fd=%b exp se=1 ec=1 sl=1 l0=0 fd=0",
                   sync_err_o, err_cnt_o, slot_o, lane_data_o[0], frame_done_o);
        else n_pass++;
      end
    end
    n_total++;
    if (frame_done_o !== 1'b1 || lane_data_o !== 4'b1001)
      $display("FAIL realign_next_frame got fd=%b ld=%b exp fd=1 ld=1001", frame_done_o, lane_data_o);
    else n_pass++;
  endtask

  task automatic test_gaps();
    logic [6:0] v  = 7'b1011001;
    logic [6:0] d  = 7'b0110011;
    logic [6:0] fs = 7'b0100111;
    obs_t got, exp;
    for (int i = 0; i < 7; i++) begin
      beat(d[i], v[i], fs[i], 1'b0);
      got = sample();
      exp = sb.pop_front();
      n_total++;
      if (got !== exp) $display("FAIL gap_beat[%0d] got=%h exp=%h", i, got, exp);
      else n_pass++;
    end
    n_total++;
    if (lane_data_o !== 4'b0101 || frame_done_o !== 1'b1)
      $display("FAIL gap_frame got ld=%b fd=%b exp ld=0101 fd=1", lane_data_o, frame_done_o);
    else n_pass++;
  endtask

  task automatic test_resync();
    obs_t got, exp;
    beat(1'b0, 1'b1, 1'b1, 1'b0); void'(sb.pop_front());
    beat(1'b1, 1'b1, 1'b0, 1'b0); void'(sb.pop_front());
    beat(1'b1, 1'b1, 1'b0, 1'b0);
    got = sample(); exp = sb.pop_front();
    n_total++;
    if (got !== exp) $display("FAIL resync_pre got=%h exp=%h", got, exp);
    else n_pass++;
    beat(1'b1, 1'b1, 1'b1, 1'b1);
    n_total++;
    if (locked_o !== 1'b0 || slot_o !== 2'd0 || lane_data_o !== 4'b0110 ||
        lane_valid_o !== 4'b0000 || err_cnt_o !== 8'd1)
      $display("FAIL resync_drop got lk=%b sl=%0d ld=%b lv=%b ec=%0d exp lk=0 sl=0 ld=0110 lv=0000 ec=1",
               locked_o, slot_o, lane_data_o, lane_valid_o, err_cnt_o);
    else n_pass++;
    void'(sb.pop_front());
    for (int i = 0; i < 3; i++) begin
      beat(1'b0, 1'b1, 1'b0, 1'b0);
      got = sample(); exp = sb.pop_front();
      n_total++;
      if (got !== exp) $display("FAIL resync_ignore[%0d] got=%h exp=%h", i, got, exp);
      else n_pass++;
    end
    beat(1'b1, 1'b1, 1'b1, 1'b0); void'(sb.pop_front());
    for (int i = 0; i < 256; i++) begin
      beat(1'b0, 1'b1, 1'b0, 1'b0);
      beat(1'b1, 1'b1, 1'b1, 1'b0);
      void'(sb.pop_front());
      got = sample(); exp = sb.pop_front();
      n_total++;
      if (got !== exp) $display("FAIL sat_err[%0d] got=%h exp=%h", i, got, exp);
      else n_pass++;
    end
    n_total++;
    if (err_cnt_o !== 8'd255 || sync_err_o !== 1'b1)
      $display("FAIL err_saturate got ec=%0d se=%b exp ec=255 se=1", err_cnt_o, sync_err_o);
    else n_pass++;
  endtask

  task automatic test_async_reset();
    obs_t got, exp;
    beat(1'b1, 1'b1, 1'b0, 1'b0); void'(sb.pop_front());
    beat(1'b1, 1'b1, 1'b1, 1'b0); void'(sb.pop_front());
    beat(1'b0, 1'b1, 1'b0, 1'b0); void'(sb.pop_front());
    beat(1'b1, 1'b1, 1'b0, 1'b0);
    got = sample(); exp = sb.pop_front();
    n_total++;
    if (got !== exp || slot_o !== 2'd3) $display("FAIL pre_reset got=%h exp=%h", got, exp);
    else n_pass++;
    #2;
    rst_n = 1'b0;
    #1;
    n_total++;
    if (sample() !== obs_t'(0)) $display("FAIL async_clear got=%h exp=%h", sample(), obs_t'(0));
    else n_pass++;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 5; i++) begin
      beat(1'b1, 1'b1, (i == 1), 1'b0);
      got = sample(); exp = sb.pop_front();
      n_total++;
      if (got !== exp) $display("FAIL rehunt[%0d] got=%h exp=%h", i, got, exp);
      else n_pass++;
    end
    n_total++;
    if (lane_data_o !== 4'b1111 || frame_done_o !== 1'b1 || err_cnt_o !== 8'd0)
      $display("FAIL rehunt_frame got ld=%b fd=%b ec=%0d exp ld=1111 fd=1 ec=0",
               lane_data_o, frame_done_o, err_cnt_o);
    else n_pass++;
  endtask

  task automatic test_non_pow2();
    logic [1:0] din_t [6] = '{2'd1, 2'd2, 2'd3, 2'd1, 2'd2, 2'd3};
    logic [1:0] slot_t[6] = '{2'd1, 2'd2, 2'd0, 2'd1, 2'd2, 2'd0};
    logic [2:0] lv_t  [6] = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
    logic       fd_t  [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 6; i++) begin
      d3_din = din_t[i]; d3_valid = 1'b1; d3_fs = (i == 0);
      @(posedge clk);
      #1;
      d3_valid = 1'b0; d3_fs = 1'b0;
      n_total++;
      if (d3_slot !== slot_t[i] || d3_fd !== fd_t[i] || d3_lv !== lv_t[i])
        $display("FAIL lanes3_beat[%0d] got sl=%0d fd=%b lv=%b exp sl=%0d fd=%b lv=%b",
                 i, d3_slot, d3_fd, d3_lv, slot_t[i], fd_t[i], lv_t[i]);
      else n_pass++;
    end
    n_total++;
    if (d3_ld !== 6'b11_10_01 || d3_lk !== 1'b1 || d3_se !== 1'b0 || d3_ec !== 8'd0)
      $display("FAIL lanes3_data got ld=%b lk=%b se=%b ec=%0d exp ld=111001 lk=1 se=0 ec=0",
               d3_ld, d3_lk, d3_se, d3_ec);
    else n_pass++;
  endtask

  initial begin
    rst_n = 1'b0;
    din_i = 1'b0; din_valid_i = 1'b0; frame_sync_i = 1'b0; resync_i = 1'b0;
    d3_din = '0; d3_valid = 1'b0; d3_fs = 1'b0; d3_rs = 1'b0;
    model_reset();
    test_reset();
    test_frame();
    test_realign();
    test_gaps();
    test_resync();
    test_async_reset();
    test_non_pow2();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
